// File: rtl/lsr_pkg.sv
// Types and constants shared by the sample window feeder and the least-squares fit stage.
package lsr_pkg;

  localparam int SAMPLE_W          = 16;
  localparam int DEFAULT_DATA_SIZE = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PRESENT,
    WAIT
  } win_state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lsr_sample_window_if.sv
// Sample stream in, frozen window out: the feeder is master, upstream source and fit stage are slave.
interface lsr_sample_window_if #(
  parameter int DATA_SIZE = lsr_pkg::DEFAULT_DATA_SIZE
);
  import lsr_pkg::*;

  logic    sample_valid;
  sample_t sample_data;
  logic    sample_ready;
  sample_t data [0:DATA_SIZE-1];
  logic    start;
  logic    fit_ack;
  logic    busy;

  modport master (
    input  sample_valid,
    input  sample_data,
    input  fit_ack,
    output sample_ready,
    output data,
    output start,
    output busy
  );

  modport slave (
    output sample_valid,
    output sample_data,
    output fit_ack,
    input  sample_ready,
    input  data,
    input  start,
    input  busy
  );

endinterface

// File: rtl/lsr_decimator.sv
// Modulo-DECIM phase counter: flags the handshake that lands on phase 0 as the one to keep.
module lsr_decimator
  import lsr_pkg::*;
#(
  parameter int DECIM = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic advance,
  input  logic clear,
  output logic keep
);

  localparam int DW = idx_width(DECIM);
  localparam logic [DW-1:0] LAST = DW'(DECIM - 1);

  logic [DW-1:0] phase_reg;

  assign keep = advance && (phase_reg == '0);

  // Clear wins over advance so a new window always starts on phase 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= '0;
    end else if (clear) begin
      phase_reg <= '0;
    end else if (advance) begin
      phase_reg <= (phase_reg == LAST) ? '0 : phase_reg + 1'b1;
    end
  end

endmodule

// File: rtl/lsr_sample_window.sv
// Fills a DATA_SIZE-deep window from a decimated sample stream, then freezes and presents it to the fit stage.
module lsr_sample_window
  import lsr_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int DECIM     = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  lsr_sample_window_if.master  bus,
  output logic [CNT_W-1:0]     window_count
);

  localparam int IW = idx_width(DATA_SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_SIZE - 1);

  win_state_t         state_reg;
  logic               ready_reg;
  logic               start_reg;
  logic               busy_reg;
  logic [IW-1:0]      wr_idx_reg;
  logic [CNT_W-1:0]   count_reg;
  sample_t            data_reg [0:DATA_SIZE-1];

  logic handshake;
  logic keep;
  logic last_write;
  logic decim_clear;

  // sample_ready is only ever high in FILL, so a handshake implies FILL.
  assign handshake  = bus.sample_valid && ready_reg;
  assign last_write = keep && (wr_idx_reg == LAST_IDX);

  // Phase restarts when a window is released or a partial window is abandoned.
  assign decim_clear = ((state_reg == WAIT) && bus.fit_ack) ||
                       ((state_reg == FILL) && !enable && !last_write);

  lsr_decimator #(
    .DECIM (DECIM)
  ) u_decimator (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (handshake),
    .clear   (decim_clear),
    .keep    (keep)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_SIZE; i++) begin
        data_reg[i] <= '0;
      end
    end else if ((state_reg == FILL) && keep) begin
      data_reg[wr_idx_reg] <= bus.sample_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      ready_reg  <= 1'b0;
      start_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      wr_idx_reg <= '0;
      count_reg  <= '0;
    end else begin
      start_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (enable) begin
            state_reg <= FILL;
            ready_reg <= 1'b1;
          end
        end
        FILL: begin
          // A completing write is honoured even if enable drops in the same cycle.
          if (last_write) begin
            state_reg  <= PRESENT;
            ready_reg  <= 1'b0;
            start_reg  <= 1'b1;
            busy_reg   <= 1'b1;
            count_reg  <= count_reg + 1'b1;
            wr_idx_reg <= '0;
          end else if (!enable) begin
            state_reg  <= IDLE;
            ready_reg  <= 1'b0;
            wr_idx_reg <= '0;
          end else if (keep) begin
            wr_idx_reg <= wr_idx_reg + 1'b1;
          end
        end
        PRESENT: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          if (bus.fit_ack) begin
            busy_reg   <= 1'b0;
            wr_idx_reg <= '0;
            ready_reg  <= enable;
            state_reg  <= enable ? FILL : IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sample_ready = ready_reg;
  assign bus.start        = start_reg;
  assign bus.busy         = busy_reg;
  assign window_count     = count_reg;

  generate
    for (genvar gi = 0; gi < DATA_SIZE; gi++) begin : g_data_out
      assign bus.data[gi] = data_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_lsr_sample_window.sv
// Bench for lsr_sample_window: three configurations behind a shared stimulus mux, windows checked by a scoreboard on start.
module tb_lsr_sample_window;
  import lsr_pkg::*;

  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] sel;
  logic       enable, valid, fit_ack;
  sample_t    sdata;

  lsr_sample_window_if #(.DATA_SIZE(4)) bus_a ();
  lsr_sample_window_if #(.DATA_SIZE(4)) bus_b ();
  lsr_sample_window_if #(.DATA_SIZE(2)) bus_c ();

  logic [CW-1:0] wc_a, wc_b, wc_c;
  logic en_a, en_b, en_c;

  assign en_a = enable && (sel == 2'd0);
  assign en_b = enable && (sel == 2'd1);
  assign en_c = enable && (sel == 2'd2);

  assign bus_a.sample_valid = valid && (sel == 2'd0);
  assign bus_b.sample_valid = valid && (sel == 2'd1);
  assign bus_c.sample_valid = valid && (sel == 2'd2);
  assign bus_a.sample_data  = sdata;
  assign bus_b.sample_data  = sdata;
  assign bus_c.sample_data  = sdata;
  assign bus_a.fit_ack      = fit_ack && (sel == 2'd0);
  assign bus_b.fit_ack      = fit_ack && (sel == 2'd1);
  assign bus_c.fit_ack      = fit_ack && (sel == 2'd2);

  lsr_sample_window #(.DATA_SIZE(4), .DECIM(1), .CNT_W(CW)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .bus(bus_a), .window_count(wc_a));
  lsr_sample_window #(.DATA_SIZE(4), .DECIM(3), .CNT_W(CW)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .bus(bus_b), .window_count(wc_b));
  lsr_sample_window #(.DATA_SIZE(2), .DECIM(1), .CNT_W(CW)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(en_c), .bus(bus_c), .window_count(wc_c));

  logic          ready, start, busy;
  logic [CW-1:0] wc;
  sample_t       dout [4];
  int            ds_cur;

  always_comb begin
    ready = bus_a.sample_ready;
    start = bus_a.start;
    busy  = bus_a.busy;
    wc    = wc_a;
    for (int i = 0; i < 4; i++) dout[i] = bus_a.data[i];
    ds_cur = 4;
    if (sel == 2'd1) begin
      ready = bus_b.sample_ready;
      start = bus_b.start;
      busy  = bus_b.busy;
      wc    = wc_b;
      for (int i = 0; i < 4; i++) dout[i] = bus_b.data[i];
    end else if (sel == 2'd2) begin
      ready   = bus_c.sample_ready;
      start   = bus_c.start;
      busy    = bus_c.busy;
      wc      = wc_c;
      dout[0] = bus_c.data[0];
      dout[1] = bus_c.data[1];
      dout[2] = '0;
      dout[3] = '0;
      ds_cur  = 2;
    end
  end

  typedef struct {
    sample_t       win [4];
    logic [CW-1:0] wc;
  } exp_t;

  typedef struct {
    logic [1:0] sel;
    int         gap;
    int         n;
    sample_t    s [10];
    sample_t    e [4];
  } vec_t;

  exp_t          exp_q [$];
  vec_t          vecs [7];
  logic [CW-1:0] wc_exp [3];

  int   checks = 0, errors = 0;
  int   cyc = 0, last_hs_cyc = -10, hs_count = 0, start_count = 0, exp_starts = 0;
  logic prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired", name);
  endtask

  // Scoreboard: each start pops one expected window.
  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (start) begin
      start_count++;
      check("start_width", prev_start, 0);
      check("start_latency", cyc - last_hs_cyc, 1);
      check("start_busy", busy, 1);
      check("start_ready", ready, 0);
      if (exp_q.size() == 0) begin
        fail_now("unexpected_start");
      end else begin
        e = exp_q.pop_front();
        for (int i = 0; i < ds_cur; i++) check($sformatf("win_data[%0d]", i), dout[i], e.win[i]);
        check("window_count", wc, e.wc);
      end
    end
    prev_start = start;
    if (valid && ready) begin
      hs_count++;
      last_hs_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input sample_t w0, input sample_t w1, input sample_t w2, input sample_t w3);
    exp_t e;
    wc_exp[sel] = wc_exp[sel] + 1'b1;
    e.win[0] = w0; e.win[1] = w1; e.win[2] = w2; e.win[3] = w3;
    e.wc = wc_exp[sel];
    exp_q.push_back(e);
    exp_starts++;
  endtask

  task automatic send(input sample_t v, input int gap);
    int tries;
    tries = 0;
    sdata = v;
    valid = 1'b1;
    @(negedge clk);
    while (!ready) begin
      tries++;
      if (tries > 300) begin
        fail_now("send_timeout");
        break;
      end
      @(negedge clk);
    end
    tick();
    valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_drained();
    int t;
    t = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      t++;
      if (t > 300) begin
        fail_now("start_timeout");
        exp_q.delete();
      end
    end
    tick();
  endtask

  task automatic ack_check();
    fit_ack = 1'b1;
    tick();
    fit_ack = 1'b0;
    @(negedge clk);
    check("ack_busy", busy, 0);
    check("ack_ready", ready, enable);
    tick();
  endtask

  task automatic reset_outputs_check(input string tag);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_wc"}, wc, 0);
    for (int i = 0; i < 4; i++) check($sformatf("%s_data[%0d]", tag, i), dout[i], 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int h0, s0;
    rst_n = 1'b0; sel = 2'd0; enable = 1'b0; valid = 1'b0; fit_ack = 1'b0; sdata = '0;
    for (int i = 0; i < 3; i++) wc_exp[i] = '0;

    vecs[0] = '{2'd0, 0, 4, '{10, 20, 30, 40, 0, 0, 0, 0, 0, 0}, '{10, 20, 30, 40}};
    vecs[1] = '{2'd0, 1, 4, '{10, 20, 30, 40, 0, 0, 0, 0, 0, 0}, '{10, 20, 30, 40}};
    vecs[2] = '{2'd0, 0, 4, '{16'hFFFF, 0, 16'h8000, 1, 0, 0, 0, 0, 0, 0}, '{16'hFFFF, 0, 16'h8000, 1}};
    vecs[3] = '{2'd1, 0, 10, '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10}, '{1, 4, 7, 10}};
    vecs[4] = '{2'd1, 1, 10, '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10}, '{1, 4, 7, 10}};
    vecs[5] = '{2'd2, 0, 2, '{7, 9, 0, 0, 0, 0, 0, 0, 0, 0}, '{7, 9, 0, 0}};
    vecs[6] = '{2'd2, 2, 2, '{16'hABCD, 16'h1234, 0, 0, 0, 0, 0, 0, 0, 0}, '{16'hABCD, 16'h1234, 0, 0}};

    #12;
    reset_outputs_check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 7; k++) begin
      sel = vecs[k].sel;
      enable = 1'b1;
      push_exp(vecs[k].e[0], vecs[k].e[1], vecs[k].e[2], vecs[k].e[3]);
      for (int i = 0; i < vecs[k].n; i++) send(vecs[k].s[i], vecs[k].gap);
      wait_drained();
      ack_check();
    end

    // Held sample during WAIT is backpressured; an ack during PRESENT is ignored.
    sel = 2'd0; enable = 1'b1;
    push_exp(10, 20, 30, 40);
    send(10, 0); send(20, 0); send(30, 0); send(40, 0);
    fit_ack = 1'b1; sdata = 16'd99; valid = 1'b1;
    tick();
    fit_ack = 1'b0;
    h0 = hs_count;
    repeat (20) tick();
    @(negedge clk);
    check("wait_no_hs", hs_count, h0);
    check("wait_busy", busy, 1);
    check("wait_ready", ready, 0);
    check("wait_data0", dout[0], 10);
    check("wait_data3", dout[3], 40);
    tick();
    fit_ack = 1'b1;
    tick();
    fit_ack = 1'b0;
    @(negedge clk);
    check("release_busy", busy, 0);
    check("release_ready", ready, 1);
    push_exp(99, 2, 3, 4);
    tick();
    valid = 1'b0;
    @(negedge clk);
    check("first_slot", dout[0], 99);
    check("old_data_held", dout[1], 20);
    tick();
    send(2, 0); send(3, 0); send(4, 0);
    wait_drained();
    ack_check();

    // DECIM=3 with samples spilling past the window: 11 opens the next window.
    sel = 2'd1; enable = 1'b1;
    push_exp(1, 4, 7, 10);
    push_exp(11, 14, 17, 20);
    fork
      begin : spill_src
        for (int i = 1; i <= 20; i++) send(sample_t'(i), 0);
      end
      begin : spill_ack
        int t, h;
        t = 0;
        while (exp_q.size() > 1 && t < 300) begin
          @(negedge clk);
          t++;
        end
        if (t >= 300) fail_now("spill_first_start");
        tick();
        h = hs_count;
        repeat (6) tick();
        @(negedge clk);
        check("spill_no_hs", hs_count, h);
        check("spill_ready", ready, 0);
        tick();
        fit_ack = 1'b1;
        tick();
        fit_ack = 1'b0;
      end
    join
    wait_drained();
    ack_check();

    // Enable dropped mid-fill discards the partial window.
    sel = 2'd0; enable = 1'b1;
    send(1, 0); send(2, 0);
    enable = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("disabled_ready", ready, 0);
    tick();
    s0 = start_count;
    enable = 1'b1;
    push_exp(5, 6, 7, 8);
    send(5, 0); send(6, 0); send(7, 0); send(8, 0);
    wait_drained();
    check("one_start", start_count - s0, 1);
    ack_check();

    // Asynchronous reset mid-fill, then during WAIT.
    send(1, 0); send(2, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    reset_outputs_check("rst_fill");
    for (int i = 0; i < 3; i++) wc_exp[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push_exp(21, 22, 23, 24);
    send(21, 0); send(22, 0); send(23, 0); send(24, 0);
    wait_drained();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    reset_outputs_check("rst_wait");
    for (int i = 0; i < 3; i++) wc_exp[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    s0 = start_count;
    repeat (15) tick();
    check("no_start_after_rst", start_count, s0);
    push_exp(31, 32, 33, 34);
    send(31, 0); send(32, 0); send(33, 0); send(34, 0);
    wait_drained();
    ack_check();

    check("total_starts", start_count, exp_starts);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
